// File: rtl/array_div_sequential.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor -> 2W-bit quotient, W-bit remainder.
// Latency 2W cycles from the accepting edge; results and done appear just after edge k+2W.
// Backpressure: start is honoured only while ready=1; a start during busy is dropped, not queued.
module array_div_sequential #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   quotient,
    output logic [W-1:0]     remainder,
    output logic             dbz
);

    localparam int              CW   = (2 * W > 1) ? $clog2(2 * W) : 1;
    localparam logic [CW-1:0]   LAST = CW'(2 * W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2*W-1:0]   dvd;
    logic [W-1:0]     dvs;
    logic [W:0]       pr;
    logic             dbz_w;

    logic [W:0]       pr_shift;
    logic [W:0]       pr_next;
    logic             qbit;
    logic [2*W-1:0]   dvd_next;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        pr_shift = {pr[W-1:0], dvd[2*W-1]};
        qbit     = (pr_shift >= {1'b0, dvs});
        pr_next  = qbit ? (pr_shift - {1'b0, dvs}) : pr_shift;
        dvd_next = {dvd[2*W-2:0], qbit};
    end

    assign busy  = (state == RUN);
    assign ready = ~busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            pr        <= '0;
            dbz_w     <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= dividend;
                        dvs   <= divisor;
                        pr    <= '0;
                        cnt   <= '0;
                        dbz_w <= (divisor == '0);
                        state <= RUN;
                    end
                end
                RUN: begin
                    pr  <= pr_next;
                    dvd <= dvd_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // With a zero divisor every step "fits", so the quotient is
                        // naturally all ones; the remainder is forced to zero.
                        quotient  <= dvd_next;
                        remainder <= dbz_w ? '0 : pr_next[W-1:0];
                        dbz       <= dbz_w;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
